// File: rtl/idma_pkg.sv
// Shared types and helpers for the iDMA OBI write engine.
package idma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        REQ
    } obi_w_state_e;

    // Widest strobe the mask helper supports (DataWidth up to 1024).
    localparam int unsigned MaxStrbWidth = 128;

    // Byte-lane mask: lanes offset..end-1 set, end = num_bytes when tailer is 0.
    function automatic logic [MaxStrbWidth-1:0] be_mask(input int unsigned offset,
                                                        input int unsigned tailer,
                                                        input int unsigned num_bytes);
        int unsigned              stop;
        logic [MaxStrbWidth-1:0]  ones;
        ones = '1;
        stop = (tailer == 0) ? num_bytes : tailer;
        return (ones << offset) & ~(ones << stop);
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Minimal non-fall-through FIFO, port-compatible with common_cells fifo_v3.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);
    localparam int unsigned CntWidth = ADDR_DEPTH + 1;

    logic [ADDR_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]   cnt_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  do_push, do_pop;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;
    assign full_o  = (cnt_q == CntWidth'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    function automatic logic [ADDR_DEPTH-1:0] next_ptr(input logic [ADDR_DEPTH-1:0] p);
        return (p == ADDR_DEPTH'(DEPTH - 1)) ? '0 : p + ADDR_DEPTH'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            mem_q    <= '{default: '0};
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - CntWidth'(1);
            end
        end
    end

endmodule

// File: rtl/idma_obi_write_engine.sv
// OBI write engine: merges a legalized write request with buffer data into one OBI write.
// Optional error reporting is enabled with `define IDMA_OBI_W_ERR_EN.
module idma_obi_write_engine
    import idma_pkg::*;
#(
    parameter  int unsigned DataWidth      = 32,
    parameter  int unsigned AddrWidth      = 32,
    parameter  int unsigned NumOutstanding = 4,
    localparam int unsigned StrbWidth      = DataWidth / 8,
    localparam int unsigned OffsetWidth    = $clog2(StrbWidth)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   w_req_valid_i,
    output logic                   w_req_ready_o,
    input  logic [AddrWidth-1:0]   w_req_addr_i,
    input  logic [OffsetWidth-1:0] w_req_offset_i,
    input  logic [OffsetWidth-1:0] w_req_tailer_i,
    input  logic                   w_req_last_i,
    input  logic                   buf_valid_i,
    output logic                   buf_ready_o,
    input  logic [DataWidth-1:0]   buf_data_i,
    input  logic [StrbWidth-1:0]   buf_strb_i,
    output logic                   obi_req_o,
    input  logic                   obi_gnt_i,
    output logic [AddrWidth-1:0]   obi_addr_o,
    output logic                   obi_we_o,
    output logic [StrbWidth-1:0]   obi_be_o,
    output logic [DataWidth-1:0]   obi_wdata_o,
    input  logic                   obi_rvalid_i,
    output logic                   obi_rready_o,
    input  logic                   obi_err_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic                   rsp_err_o,
    output logic                   busy_o
);
    localparam int unsigned UsageWidth = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;

    obi_w_state_e           state_q, state_d;
    logic [AddrWidth-1:0]   addr_q;
    logic [OffsetWidth-1:0] offset_q, tailer_q;
    logic                   last_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [StrbWidth-1:0]   be_q, be_d;
    logic                   req_hs, buf_hs, a_hs, r_beat;
    logic                   fifo_full, fifo_empty, fifo_head;
    logic [UsageWidth-1:0]  fifo_usage_unused;
    logic                   rsp_valid_q, rsp_valid_d;

    assign be_d = StrbWidth'(be_mask(32'(offset_q), 32'(tailer_q), StrbWidth)) & buf_strb_i;

    // Request sequencing; data is only taken while an outstanding slot is free.
    always_comb begin
        state_d       = state_q;
        w_req_ready_o = 1'b0;
        buf_ready_o   = 1'b0;
        obi_req_o     = 1'b0;
        case (state_q)
            IDLE: begin
                w_req_ready_o = 1'b1;
                if (w_req_valid_i) state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (buf_valid_i && !fifo_full) begin
                    buf_ready_o = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                obi_req_o = 1'b1;
                if (obi_gnt_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    assign req_hs = w_req_valid_i && w_req_ready_o;
    assign buf_hs = buf_valid_i && buf_ready_o;
    assign a_hs   = obi_req_o && obi_gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            offset_q <= '0;
            tailer_q <= '0;
            last_q   <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
        end else begin
            if (req_hs) begin
                addr_q   <= w_req_addr_i;
                offset_q <= w_req_offset_i;
                tailer_q <= w_req_tailer_i;
                last_q   <= w_req_last_i;
            end
            if (buf_hs) begin
                wdata_q <= buf_data_i;
                be_q    <= be_d;
            end
        end
    end

    assign obi_addr_o  = addr_q;
    assign obi_be_o    = be_q;
    assign obi_wdata_o = wdata_q;
    assign obi_we_o    = (state_q == REQ);

    // Tracks the last flag of every granted write until its R beat returns.
    fifo_v3 #(
        .DATA_WIDTH (1),
        .DEPTH      (NumOutstanding)
    ) i_outstanding (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .usage_o    (fifo_usage_unused),
        .data_i     (last_q),
        .push_i     (a_hs),
        .data_o     (fifo_head),
        .pop_i      (r_beat)
    );

    assign obi_rready_o = !rsp_valid_q || rsp_ready_i;
    assign r_beat       = obi_rvalid_i && obi_rready_o;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        if (rsp_valid_q && rsp_ready_i) rsp_valid_d = 1'b0;
        if (r_beat && fifo_head)        rsp_valid_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rsp_valid_q <= 1'b0;
        else         rsp_valid_q <= rsp_valid_d;
    end

    assign rsp_valid_o = rsp_valid_q;
    assign busy_o      = (state_q != IDLE) || !fifo_empty;

`ifdef IDMA_OBI_W_ERR_EN
    logic err_q, err_d;

    // Sticky over all beats of a transfer; restarts once the response is taken.
    always_comb begin
        err_d = err_q;
        if (rsp_valid_q && rsp_ready_i) err_d = 1'b0;
        if (r_beat)                     err_d = err_d | obi_err_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign rsp_err_o = rsp_valid_q && err_q;
`else
    logic unused_err;
    assign unused_err = obi_err_i;
    assign rsp_err_o  = 1'b0;
`endif

    assert property (@(posedge clk_i) disable iff (!rst_ni) r_beat |-> !fifo_empty);

endmodule
